// File: rtl/tof_frame_streamer_pkg.sv
// Shared types and constants for the ToF frame streamer: FSM states, header
// layout and default frame geometry.
package tof_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        RD   = 2'd2,
        TRL  = 2'd3
    } tof_state_e;

    localparam int N_ZONES_DEF  = 512;
    localparam int DIST_W_DEF   = 16;
    localparam int ADDR_W_DEF   = 9;
    localparam logic [7:0] SYNC_DEF = 8'hA5;

    localparam int HDR_SYNC_LSB  = 24;
    localparam int HDR_OVR_BIT   = 23;
    localparam int HDR_FRESH_BIT = 22;
    localparam int HDR_CNT_W     = 16;

    localparam int FRAME_WORDS = 2 + N_ZONES_DEF / 2;
    // Skid entry: {last, user, data[31:0]}
    localparam int SKID_W = 34;

    function automatic logic [31:0] make_header(input logic [7:0] sync,
                                                input logic ovr,
                                                input logic fresh,
                                                input logic [HDR_CNT_W-1:0] cnt);
        return {sync, ovr, fresh, 6'b0, cnt};
    endfunction

endpackage

// File: rtl/tof_frame_streamer_if.sv
// AXI4-Stream style output bundle of the frame streamer.
// A word transfers on a clock edge where tvalid and tready are both 1; once
// tvalid rises, tdata/tlast/tuser hold and tvalid stays high until that edge.
interface tof_frame_streamer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
    logic        tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser,
                    input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser,
                    output tready);
endinterface

// File: rtl/tof_frame_streamer_skid.sv
// Two-entry FIFO that absorbs payload words still returning from the BRAM
// while the stream sink is stalled.
module tof_stream_skid
    import tof_stream_pkg::*;
#(
    parameter int W = SKID_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign wr_en     = in_valid && in_ready;
    assign rd_en     = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, wr_en} - {1'b0, rd_en};
        end
    end
endmodule

// File: rtl/tof_frame_streamer.sv
// Streams one ToF distance frame out of BRAM as header, packed distance pairs
// and a plane-fit trailer on an AXI4-Stream style port.
module tof_frame_streamer
    import tof_stream_pkg::*;
#(
    parameter int         N_ZONES = N_ZONES_DEF,
    parameter int         DIST_W  = DIST_W_DEF,
    parameter int         ADDR_W  = ADDR_W_DEF,
    parameter logic [7:0] SYNC    = SYNC_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_rdy,
    input  logic                 plane_vld,
    input  logic [31:0]          plane_data,
    output logic [ADDR_W-1:0]    bram_addr,
    input  logic [DIST_W-1:0]    bram_dout,
    tof_frame_streamer_if.master m_axis,
    output logic                 busy,
    output logic [15:0]          drop_cnt,
    output tof_state_e           dbg_state
);
    localparam int CNT_W = ADDR_W + 1;

    tof_state_e state_q, state_d;

    logic [CNT_W-1:0]  addr_cnt;
    logic              rd_vld, rd_odd;
    logic [DIST_W-1:0] even_q;
    logic [31:0]       out_q, plane_q;
    logic              plane_fresh, overrun, drop_seen, rst_seen;
    logic [15:0]       frame_cnt;

    logic              hdr_load, trl_load, trl_done, issue;
    logic              push, pop, room, issue_done, drain_done, drop_evt;
    logic              skid_in_rdy, skid_vld;
    logic [SKID_W-1:0] skid_din, skid_dout;
    logic [1:0]        skid_cnt;

    assign push       = rd_vld && rd_odd;
    assign pop        = (state_q == RD) && skid_vld && m_axis.tready;
    // A pair completing this cycle is not yet in skid_cnt, so count it as occupied.
    assign room       = skid_in_rdy && !(skid_cnt == 2'd1 && push);
    assign issue_done = (addr_cnt == CNT_W'(N_ZONES));
    assign drain_done = issue_done && !rd_vld &&
                        (skid_cnt == 2'd0 || (skid_cnt == 2'd1 && pop));
    assign drop_evt   = frame_rdy && (state_q != IDLE);
    assign skid_din   = {2'b00, bram_dout, even_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        hdr_load = 1'b0;
        trl_load = 1'b0;
        trl_done = 1'b0;
        issue    = 1'b0;
        case (state_q)
            IDLE: if (frame_rdy && rst_seen) begin
                state_d  = HDR;
                hdr_load = 1'b1;
            end
            HDR: if (m_axis.tready) state_d = RD;
            RD: begin
                issue = !issue_done && room;
                if (drain_done) begin
                    state_d  = TRL;
                    trl_load = 1'b1;
                end
            end
            TRL: if (m_axis.tready) begin
                state_d  = IDLE;
                trl_done = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_seen    <= 1'b0;
            addr_cnt    <= '0;
            rd_vld      <= 1'b0;
            rd_odd      <= 1'b0;
            even_q      <= '0;
            out_q       <= '0;
            plane_q     <= '0;
            plane_fresh <= 1'b0;
            frame_cnt   <= '0;
            drop_cnt    <= '0;
            drop_seen   <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            rst_seen <= 1'b1;
            if (hdr_load)   addr_cnt <= '0;
            else if (issue) addr_cnt <= addr_cnt + 1'b1;
            rd_vld <= issue;
            if (issue) rd_odd <= addr_cnt[0];
            if (rd_vld && !rd_odd) even_q <= bram_dout;

            // Header and trailer are frozen here so they cannot change while stalled.
            if (hdr_load)
                out_q <= make_header(SYNC, overrun, plane_fresh, frame_cnt);
            else if (trl_load)
                out_q <= plane_q;

            if (plane_vld) begin
                plane_q     <= plane_data;
                plane_fresh <= 1'b1;
            end else if (trl_done) begin
                plane_fresh <= 1'b0;
            end

            if (trl_done) frame_cnt <= frame_cnt + 16'd1;
            if (drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;

            // Trailer clears only overruns already reported; drops during this frame persist.
            if (hdr_load)      drop_seen <= 1'b0;
            else if (drop_evt) drop_seen <= 1'b1;
            if (trl_done)      overrun <= drop_seen || drop_evt;
            else if (drop_evt) overrun <= 1'b1;
        end
    end

    tof_stream_skid #(.W(SKID_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (push),
        .in_ready  (skid_in_rdy),
        .in_data   (skid_din),
        .out_valid (skid_vld),
        .out_ready ((state_q == RD) && m_axis.tready),
        .out_data  (skid_dout),
        .count     (skid_cnt)
    );

    assign m_axis.tvalid = (state_q == HDR) || (state_q == TRL) ||
                           ((state_q == RD) && skid_vld);
    assign m_axis.tdata  = (state_q == RD) ? skid_dout[31:0] : out_q;
    assign m_axis.tlast  = (state_q == TRL) || ((state_q == RD) && skid_dout[33]);
    assign m_axis.tuser  = (state_q == HDR) || ((state_q == RD) && skid_dout[32]);

    assign bram_addr = addr_cnt[ADDR_W-1:0];
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;
endmodule
